perf_counter_bank: RTL and testbench

//  Synthesizable, CSR-readable hardware performance-counter bank; successor to the sim-only perf hook.
//  NUM_CNT counters, each CNT_W bits, each counting one event chosen at runtime from an NUM_EVT-bit event vector.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_counter_slice.sv | 65 ++++++
 rtl/perf_counter_bank.sv | 161 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank:
// event indices and default CSR address map.
package perf_pkg;

  localparam int EVT_CYCLE     = 0;
  localparam int EVT_IFU_VALID = 1;
  localparam int EVT_IC_ACCESS = 2;
  localparam int EVT_IC_HIT    = 3;
  localparam int EVT_LSU_LOAD  = 4;
  localparam int EVT_LSU_STORE = 5;
  localparam int EVT_LSU_WAIT  = 6;
  localparam int EVT_RSVD      = 7;

  localparam logic [11:0] PERF_SEL_BASE = 12'h7D0;
  localparam logic [11:0] PERF_LO_BASE  = 12'hB00;
  localparam logic [11:0] PERF_HI_BASE  = 12'hB80;
  localparam logic [11:0] PERF_INH_ADDR = 12'h7C0;
  localparam logic [11:0] PERF_OVF_ADDR = 12'h7C1;

endpackage

// File: rtl/perf_counter_slice.sv
// One counter with its hi-half read shadow and sticky
// overflow flag; CSR writes take priority over counting.
module perf_counter_slice #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic             snap_i,
  input  logic             clr_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-33:0] hi_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-33:0] hi_q, hi_d;
  logic              ovf_q, ovf_d;
  logic              wrap;

  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (wr_lo_i) begin
      cnt_d = {cnt_q[CNT_W-1:32], wdata_i};
    end else if (wr_hi_i) begin
      cnt_d = {wdata_i[CNT_W-33:0], cnt_q[31:0]};
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      wrap  = &cnt_q;
    end
  end

  // a new wrap beats a simultaneous W1C
  assign ovf_d = wrap | (ovf_q & ~clr_i);

  always_comb begin
    hi_d = hi_q;
    if (wr_hi_i) begin
      hi_d = wdata_i[CNT_W-33:0];
    end else if (snap_i) begin
      hi_d = cnt_q[CNT_W-1:32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hi_o  = hi_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// CSR-mapped performance-counter bank. Define PERF_OVF_IRQ_EN
// to add the overflow interrupt-enable reg and ovf_irq.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int          NUM_CNT  = 8,
  parameter int          CNT_W    = 64,
  parameter int          NUM_EVT  = 8,
  parameter logic [11:0] SEL_BASE = PERF_SEL_BASE,
  parameter logic [11:0] LO_BASE  = PERF_LO_BASE,
  parameter logic [11:0] HI_BASE  = PERF_HI_BASE,
  parameter logic [11:0] INH_ADDR = PERF_INH_ADDR,
  parameter logic [11:0] OVF_ADDR = PERF_OVF_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               csr_wen,
  input  logic [11:0]        csr_waddr,
  input  logic [31:0]        csr_wdata,
  input  logic               csr_ren,
  input  logic [11:0]        csr_raddr,
  output logic               csr_rvalid,
  output logic [31:0]        csr_rdata,
  output logic               ovf_irq
);

  localparam int SW = $clog2(NUM_EVT);

  logic [NUM_EVT-1:0] evt_q;
  logic [SW-1:0]      sel_q [NUM_CNT];
  logic [SW-1:0]      sel_d [NUM_CNT];
  logic [NUM_CNT-1:0] inh_q, inh_d;
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] inc, wr_lo, wr_hi;
  logic [NUM_CNT-1:0] snap, clr;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [CNT_W-33:0]  hi  [NUM_CNT];
  logic               rvalid_q;
  logic [31:0]        rdata_q, rdata_d;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    assign inc[g]   = evt_q[sel_q[g]] & ~inh_q[g];
    assign wr_lo[g] = csr_wen
                    && csr_waddr == LO_BASE + 12'(g);
    assign wr_hi[g] = csr_wen
                    && csr_waddr == HI_BASE + 12'(g);
    assign snap[g]  = csr_ren
                    && csr_raddr == LO_BASE + 12'(g);
    assign clr[g]   = csr_wen && csr_wdata[g]
                    && csr_waddr == OVF_ADDR;

    perf_counter_slice #(
      .CNT_W (CNT_W)
    ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (inc[g]),
      .wr_lo_i (wr_lo[g]),
      .wr_hi_i (wr_hi[g]),
      .snap_i  (snap[g]),
      .clr_i   (clr[g]),
      .wdata_i (csr_wdata),
      .cnt_o   (cnt[g]),
      .hi_o    (hi[g]),
      .ovf_o   (ovf[g])
    );
  end

  always_comb begin
    inh_d = inh_q;
    if (csr_wen && csr_waddr == INH_ADDR) begin
      inh_d = csr_wdata[NUM_CNT-1:0];
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      sel_d[i] = sel_q[i];
      if (csr_wen
          && csr_waddr == SEL_BASE + 12'(i)) begin
        sel_d[i] = csr_wdata[SW-1:0];
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  localparam logic [11:0] IE_ADDR = OVF_ADDR + 12'd1;

  logic [NUM_CNT-1:0] ie_q, ie_d;
  logic               irq_q;

  always_comb begin
    ie_d = ie_q;
    if (csr_wen && csr_waddr == IE_ADDR) begin
      ie_d = csr_wdata[NUM_CNT-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= |(ovf & ie_q);
    end
  end

  assign ovf_irq = irq_q;
`else
  assign ovf_irq = 1'b0;
`endif

  // all sources are pre-edge, so a same-cycle write is not seen
  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      csr_raddr == INH_ADDR: rdata_d = 32'(inh_q);
      csr_raddr == OVF_ADDR: rdata_d = 32'(ovf);
`ifdef PERF_OVF_IRQ_EN
      csr_raddr == IE_ADDR:  rdata_d = 32'(ie_q);
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_raddr == SEL_BASE + 12'(i)) begin
        rdata_d = 32'(sel_q[i]);
      end
      if (csr_raddr == LO_BASE + 12'(i)) begin
        rdata_d = cnt[i][31:0];
      end
      if (csr_raddr == HI_BASE + 12'(i)) begin
        rdata_d = 32'(hi[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q    <= '0;
      inh_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        sel_q[i] <= SW'(i % NUM_EVT);
      end
    end else begin
      evt_q    <= evt;
      inh_q    <= inh_d;
      rvalid_q <= csr_ren;
      if (csr_ren) begin
        rdata_q <= rdata_d;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        sel_q[i] <= sel_d[i];
      end
    end
  end

  assign csr_rvalid = rvalid_q;
  assign csr_rdata  = rdata_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: directed scenarios
// plus random CSR traffic against an arithmetic model.
module tb_perf_counter_bank;

  localparam int NC = 8;
`ifdef PERF_OVF_IRQ_EN
  localparam bit HAS_IE = 1'b1;
`else
  localparam bit HAS_IE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  evt = '0;
  logic        csr_wen = 1'b0;
  logic [11:0] csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_ren = 1'b0;
  logic [11:0] csr_raddr = '0;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        ovf_irq;

  always #5 clk = ~clk;

  perf_counter_bank dut (
    .clk        (clk),
    .reset      (reset),
    .evt        (evt),
    .csr_wen    (csr_wen),
    .csr_waddr  (csr_waddr),
    .csr_wdata  (csr_wdata),
    .csr_ren    (csr_ren),
    .csr_raddr  (csr_raddr),
    .csr_rvalid (csr_rvalid),
    .csr_rdata  (csr_rdata),
    .ovf_irq    (ovf_irq)
  );

  // reference model state
  logic [63:0] m_cnt [NC];
  logic [31:0] m_sh  [NC];
  logic [2:0]  m_sel [NC];
  logic [7:0]  m_inh, m_ovf, m_ie, m_evtq;
  logic        m_irq;

  logic [43:0] exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0;
      m_sh[i]  = '0;
      m_sel[i] = 3'(i);
    end
    m_inh  = '0;
    m_ovf  = '0;
    m_ie   = '0;
    m_evtq = '0;
    m_irq  = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(
    input logic [11:0] a
  );
    if (a == 12'h7C0) return 32'(m_inh);
    if (a == 12'h7C1) return 32'(m_ovf);
    if (HAS_IE && a == 12'h7C2) return 32'(m_ie);
    for (int i = 0; i < NC; i++) begin
      if (a == 12'h7D0 + 12'(i)) return 32'(m_sel[i]);
      if (a == 12'hB00 + 12'(i)) return m_cnt[i][31:0];
      if (a == 12'hB80 + 12'(i)) return m_sh[i];
    end
    return 32'h0;
  endfunction

  // one clock edge of the architectural rules
  function automatic void m_step();
    logic [7:0]  novf;
    logic        nirq;
    logic [63:0] nxt;
    if (reset) begin
      m_reset();
      return;
    end
    nirq = |(m_ovf & m_ie);
    novf = m_ovf;
    if (csr_wen && csr_waddr == 12'h7C1)
      novf = novf & ~csr_wdata[7:0];
    for (int i = 0; i < NC; i++) begin
      if (csr_ren && csr_raddr == 12'hB00 + 12'(i))
        m_sh[i] = m_cnt[i][63:32];
      if (csr_wen && csr_waddr == 12'hB00 + 12'(i)) begin
        m_cnt[i][31:0] = csr_wdata;
      end else if (csr_wen
                   && csr_waddr == 12'hB80 + 12'(i)) begin
        m_cnt[i][63:32] = csr_wdata;
        m_sh[i] = csr_wdata;
      end else if (m_evtq[m_sel[i]] && !m_inh[i]) begin
        nxt = m_cnt[i] + 64'd1;
        if (nxt < m_cnt[i]) novf[i] = 1'b1;
        m_cnt[i] = nxt;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (csr_wen && csr_waddr == 12'h7D0 + 12'(i))
        m_sel[i] = csr_wdata[2:0];
    end
    if (csr_wen && csr_waddr == 12'h7C0)
      m_inh = csr_wdata[7:0];
    if (HAS_IE && csr_wen && csr_waddr == 12'h7C2)
      m_ie = csr_wdata[7:0];
    m_ovf  = novf;
    m_irq  = HAS_IE ? nirq : 1'b0;
    m_evtq = evt;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h",
               name, act, exp);
    end
  endtask

  task automatic step();
    if (csr_ren && !reset)
      exp_q.push_back({csr_raddr, m_read(csr_raddr)});
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(
    input logic [11:0] a,
    input logic [31:0] d
  );
    csr_wen = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    step();
    csr_wen = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_ren = 1'b1;
    csr_raddr = a;
    step();
    csr_ren = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever data is presented
  always @(negedge clk) begin
    logic [43:0] e;
    if (mon_en) begin
      if (csr_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'(csr_rvalid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rdata@%h", e[43:32]),
              csr_rdata, e[31:0]);
        end
      end
      chk("ovf_irq", 32'(ovf_irq), 32'(m_irq));
    end
  end

  function automatic logic [11:0] pick();
    case ($urandom % 7)
      0: return 12'h7D0 + 12'($urandom % 10);
      1: return 12'hB00 + 12'($urandom % 10);
      2: return 12'hB80 + 12'($urandom % 10);
      3: return 12'h7C0;
      4: return 12'h7C1;
      5: return 12'h7C2;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pickd();
    case ($urandom % 4)
      0: return 32'hFFFF_FFFF;
      1: return 32'hFFFF_FFF0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_reset();
    do_reset();
    mon_en = 1'b1;
    chk("rst_rvalid", 32'(csr_rvalid), 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_irq", 32'(ovf_irq), 32'h0);
    for (int i = 0; i < NC; i++) rd(12'h7D0 + 12'(i));
    rd(12'h7C0);
    rd(12'h7C1);
    rd(12'h7C2);

    // counter 0 on evt[0]
    evt = 8'h01;
    idle(10);
    evt = 8'h00;
    idle(2);
    rd(12'hB00);
    rd(12'hB80);
    rd(12'hB01);

    // wrap of counter 2
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'hFFFF_FFFF);
    wr(12'h7D2, 32'h0);
    evt = 8'h01;
    step();
    evt = 8'h00;
    idle(2);
    rd(12'hB02);
    rd(12'hB82);
    rd(12'h7C1);
    wr(12'h7C1, 32'h4);
    rd(12'h7C1);

    // carry into hi, shadow write-through
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0);
    wr(12'h7D3, 32'h0);
    evt = 8'h01;
    step();
    evt = 8'h00;
    idle(2);
    rd(12'hB03);
    rd(12'hB83);
    wr(12'hB83, 32'h5);
    rd(12'hB83);

    // tear-free read across a carry
    wr(12'hB04, 32'hFFFF_FFFE);
    wr(12'hB84, 32'h0);
    wr(12'h7D4, 32'h0);
    rd(12'hB04);
    evt = 8'h01;
    idle(2);
    evt = 8'h00;
    idle(2);
    rd(12'hB84);
    rd(12'hB04);
    rd(12'hB84);

    // inhibit, and write beating an increment
    wr(12'h7C0, 32'h1);
    evt = 8'h01;
    idle(5);
    evt = 8'h00;
    idle(2);
    rd(12'hB00);
    wr(12'h7C0, 32'h0);
    evt = 8'h01;
    step();
    evt = 8'h00;
    wr(12'hB00, 32'h0000_1234);
    idle(2);
    rd(12'hB00);

    // same-cycle read and write of one address
    csr_wen = 1'b1;
    csr_waddr = 12'hB01;
    csr_wdata = 32'hCAFE_0001;
    csr_ren = 1'b1;
    csr_raddr = 12'hB01;
    step();
    csr_wen = 1'b0;
    csr_ren = 1'b0;
    rd(12'hB01);
    rd(12'hB10);
    wr(12'hB08, 32'h55);
    rd(12'hB08);

    // interrupt path
    wr(12'h7C2, 32'h1);
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'h7D0, 32'h0);
    evt = 8'h01;
    step();
    evt = 8'h00;
    idle(3);
    rd(12'h7C1);
    wr(12'h7C1, 32'hFF);
    idle(2);
    rd(12'h7C2);

    // reset on top of a read request
    rd(12'hB00);
    csr_ren = 1'b1;
    csr_raddr = 12'hB00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    csr_ren = 1'b0;
    chk("rst_mid_rvalid", 32'(csr_rvalid), 32'h0);
    chk("rst_mid_rdata", csr_rdata, 32'h0);
    idle(1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      evt = 8'($urandom);
      csr_wen = ($urandom % 3) == 0;
      csr_waddr = pick();
      csr_wdata = pickd();
      csr_ren = ($urandom % 2) == 0;
      csr_raddr = (($urandom % 6) == 0)
                ? csr_waddr : pick();
      step();
    end
    csr_wen = 1'b0;
    csr_ren = 1'b0;
    evt = 8'h00;
    idle(3);
    for (int i = 0; i < NC; i++) begin
      rd(12'hB00 + 12'(i));
      rd(12'hB80 + 12'(i));
    end
    rd(12'h7C1);
    idle(3);
    chk("pending_reads", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
